dmem_arbiter: RTL

Two-requester arbiter that shares the single-port, byte-addressed program data memory between the core's load/store path (port 0) and the program loader/debug port (port 1). It selects one requester per cycle and drives the memory's write-enable, store-size, address and write-data inputs. It returns registered read data to the winning requester. Round-robin fairness applies, with an optional bounded lock for back-to-back bursts.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned PROG_WIDTH = 10
);
    logic                  req0;
    logic                  we0;
    logic [1:0]            ctrl_store0;
    logic [PROG_WIDTH-1:0] addr0;
    logic [31:0]           wdata0;
    logic                  lock0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [31:0]           rdata0;

    logic                  req1;
    logic                  we1;
    logic [1:0]            ctrl_store1;
    logic [PROG_WIDTH-1:0] addr1;
    logic [31:0]           wdata1;
    logic                  lock1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [31:0]           rdata1;

    logic                  mem_we;
    logic [1:0]            mem_ctrl;
    logic [PROG_WIDTH-1:0] mem_A;
    logic [31:0]           mem_WD;
    logic [31:0]           mem_data_out;

    modport slave (
        input  req0, we0, ctrl_store0, addr0, wdata0, lock0,
        input  req1, we1, ctrl_store1, addr1, wdata1, lock1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_ctrl, mem_A, mem_WD,
        input  mem_data_out
    );

    modport master (
        output req0, we0, ctrl_store0, addr0, wdata0, lock0,
        output req1, we1, ctrl_store1, addr1, wdata1, lock1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_ctrl, mem_A, mem_WD,
        output mem_data_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the core (port 0) and the loader (port 1),
// with a bounded lock for bursts and registered read-data return.
module dmem_arbiter #(
    parameter int unsigned PROG_WIDTH = 10,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus_io
);
    localparam logic [3:0] MaxCnt = 4'(MAX_BURST);

    logic        last_gnt_q, last_gnt_d;
    logic        owner_q, owner_d;
    logic        owner_valid_q, owner_valid_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic gnt0, gnt1, granted, lock_hold, win_lock;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        lock_hold = owner_valid_q && (owner_q ? bus_io.lock1 : bus_io.lock0) &&
                    (burst_cnt_q < MaxCnt);
        if (!rst) begin
            if (bus_io.req0 && !bus_io.req1) begin
                gnt0 = 1'b1;
            end else if (bus_io.req1 && !bus_io.req0) begin
                gnt1 = 1'b1;
            end else if (bus_io.req0 && bus_io.req1) begin
                // Lock wins until the burst budget runs out, then plain round-robin.
                if (lock_hold) begin
                    gnt1 = owner_q;
                end else begin
                    gnt1 = ~last_gnt_q;
                end
                gnt0 = ~gnt1;
            end
        end
        granted  = gnt0 | gnt1;
        win_lock = gnt1 ? bus_io.lock1 : bus_io.lock0;
    end

    always_comb begin
        bus_io.mem_we   = 1'b0;
        bus_io.mem_ctrl = 2'b00;
        bus_io.mem_A    = {PROG_WIDTH{1'b0}};
        bus_io.mem_WD   = 32'h0;
        if (gnt0) begin
            bus_io.mem_we   = bus_io.we0;
            bus_io.mem_ctrl = bus_io.ctrl_store0;
            bus_io.mem_A    = bus_io.addr0;
            bus_io.mem_WD   = bus_io.wdata0;
        end else if (gnt1) begin
            bus_io.mem_we   = bus_io.we1;
            bus_io.mem_ctrl = bus_io.ctrl_store1;
            bus_io.mem_A    = bus_io.addr1;
            bus_io.mem_WD   = bus_io.wdata1;
        end
    end

    always_comb begin
        last_gnt_d    = granted ? gnt1 : last_gnt_q;
        owner_d       = owner_q;
        owner_valid_d = 1'b0;
        burst_cnt_d   = 4'd0;
        if (granted && win_lock) begin
            owner_valid_d = 1'b1;
            if (owner_valid_q && (owner_q == gnt1)) begin
                burst_cnt_d = (burst_cnt_q < MaxCnt) ? burst_cnt_q + 4'd1 : MaxCnt;
            end else begin
                owner_d     = gnt1;
                burst_cnt_d = 4'd1;
            end
        end
        rvalid0_d = gnt0 & ~bus_io.we0;
        rvalid1_d = gnt1 & ~bus_io.we1;
        rdata0_d  = rvalid0_d ? bus_io.mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? bus_io.mem_data_out : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q    <= 1'b1;
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            burst_cnt_q   <= 4'd0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= 32'h0;
            rdata1_q      <= 32'h0;
        end else begin
            last_gnt_q    <= last_gnt_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign bus_io.gnt0    = gnt0;
    assign bus_io.gnt1    = gnt1;
    assign bus_io.rvalid0 = rvalid0_q;
    assign bus_io.rvalid1 = rvalid1_q;
    assign bus_io.rdata0  = rdata0_q;
    assign bus_io.rdata1  = rdata1_q;
endmodule
